// File: rtl/chacha_aead_sequencer.sv
// chacha_aead_sequencer: drives one ChaCha20-Poly1305 block operation over the
// AEAD register bus. It programs mode/key/nonce/data, pulses init, polls status
// (ignoring the first POLL_SKIP reads), then reads back the data block and tag.
//
// Handshakes: the requester side is a start/ready pair: a request is taken on
// any cycle where start=1 and ready=1 (ready is high only while idle), and the
// result is announced by a single-cycle done pulse with data_out/tag_out/tag_ok/err
// stable from that cycle until the next accepted start. The bus side issues at
// most one access per cycle (bus_cs=1); read data returns on bus_rdata one cycle
// after the read access.
//
// The FSM state is kept in state_q for external checkers to observe.
module chacha_aead_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int POLL_SKIP      = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic         ready,
  input  logic         encdec,
  input  logic         key_reuse,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [511:0] data_in,
  output logic         done,
  output logic         err,
  output logic         tag_ok,
  output logic [511:0] data_out,
  output logic [127:0] tag_out,
  output logic         bus_cs,
  output logic         bus_we,
  output logic [7:0]   bus_addr,
  output logic [511:0] bus_wdata,
  input  logic [511:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(POLL_SKIP + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_WR_KEY, S_WR_NONCE, S_WR_DATA, S_INIT_SET, S_INIT_CLR,
    S_POLL_REQ, S_POLL_CHK, S_RD_DATA_REQ, S_RD_DATA_CAP, S_RD_TAG_REQ,
    S_RD_TAG_CAP, S_TO_CLR, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     word_q, word_d;
  logic [SW-1:0]  skip_q, skip_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic           encdec_q, encdec_d;
  logic           key_reuse_q, key_reuse_d;
  logic [255:0]   key_q, key_d;
  logic [95:0]    nonce_q, nonce_d;
  logic [511:0]   data_q, data_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           tag_ok_q, tag_ok_d;
  logic [511:0]   data_out_q, data_out_d;
  logic [127:0]   tag_out_q, tag_out_d;
  logic           bus_cs_q, bus_cs_d;
  logic           bus_we_q, bus_we_d;
  logic [7:0]     bus_addr_q, bus_addr_d;
  logic [511:0]   bus_wdata_q, bus_wdata_d;
  logic [255:0]   key_sh;
  logic [95:0]    nonce_sh;
  logic           poll_expired;

  assign ready     = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign tag_ok    = tag_ok_q;
  assign data_out  = data_out_q;
  assign tag_out   = tag_out_q;
  assign bus_cs    = bus_cs_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

  assign poll_expired = (cyc_q == CW'(TIMEOUT_CYCLES - 1));

  // Next-state, request latching, poll bookkeeping and result capture.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    skip_d      = skip_q;
    cyc_d       = cyc_q;
    encdec_d    = encdec_q;
    key_reuse_d = key_reuse_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    data_d      = data_q;
    err_d       = err_q;
    tag_ok_d    = tag_ok_q;
    data_out_d  = data_out_q;
    tag_out_d   = tag_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WR_MODE;
          encdec_d    = encdec;
          key_reuse_d = key_reuse;
          key_d       = key;
          nonce_d     = nonce;
          data_d      = data_in;
          err_d       = 1'b0;
          tag_ok_d    = 1'b0;
          data_out_d  = '0;
          tag_out_d   = '0;
        end
      end
      S_WR_MODE: begin
        word_d  = 3'd0;
        state_d = key_reuse_q ? S_WR_NONCE : S_WR_KEY;
      end
      S_WR_KEY: begin
        word_d = word_q + 3'd1;
        if (word_q == 3'd7) state_d = S_WR_NONCE;
      end
      S_WR_NONCE: begin
        if (word_q == 3'd2) begin
          word_d  = 3'd0;
          state_d = S_WR_DATA;
        end else begin
          word_d = word_q + 3'd1;
        end
      end
      S_WR_DATA:  state_d = S_INIT_SET;
      S_INIT_SET: begin
        // Poll bookkeeping restarts as INIT_CLR is entered.
        cyc_d   = '0;
        skip_d  = '0;
        state_d = S_INIT_CLR;
      end
      S_INIT_CLR: state_d = S_POLL_REQ;
      S_POLL_REQ: begin
        if (poll_expired) begin
          state_d = S_TO_CLR;
        end else begin
          cyc_d   = cyc_q + CW'(1);
          state_d = S_POLL_CHK;
        end
      end
      S_POLL_CHK: begin
        if (poll_expired) begin
          state_d = S_TO_CLR;
        end else begin
          cyc_d = cyc_q + CW'(1);
          if (skip_q < SW'(POLL_SKIP)) begin
            // Early status reads may still show the previous block's valid.
            skip_d  = skip_q + SW'(1);
            state_d = S_POLL_REQ;
          end else if (bus_rdata[0] && bus_rdata[1]) begin
            tag_ok_d = bus_rdata[2];
            state_d  = S_RD_DATA_REQ;
          end else begin
            state_d = S_POLL_REQ;
          end
        end
      end
      S_RD_DATA_REQ: state_d = S_RD_DATA_CAP;
      S_RD_DATA_CAP: begin
        data_out_d = bus_rdata;
        state_d    = S_RD_TAG_REQ;
      end
      S_RD_TAG_REQ: state_d = S_RD_TAG_CAP;
      S_RD_TAG_CAP: begin
        tag_out_d = bus_rdata[127:0];
        state_d   = S_DONE;
      end
      S_TO_CLR: begin
        err_d      = 1'b1;
        tag_ok_d   = 1'b0;
        data_out_d = '0;
        tag_out_d  = '0;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus access for the state being entered, so the bus pins come straight from flops.
  always_comb begin
    key_sh      = key_d << {word_d, 5'd0};
    nonce_sh    = nonce_d >> {word_d, 5'd0};
    bus_cs_d    = 1'b0;
    bus_we_d    = 1'b0;
    bus_addr_d  = 8'h00;
    bus_wdata_d = '0;
    ready_d     = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);
    case (state_d)
      S_WR_MODE:  begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = 8'h0a; bus_wdata_d = {511'b0, encdec_d}; end
      S_WR_KEY:   begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = 8'h10 + {5'b0, word_d}; bus_wdata_d = {480'b0, key_sh[255:224]}; end
      S_WR_NONCE: begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = 8'h20 + {5'b0, word_d}; bus_wdata_d = {480'b0, nonce_sh[31:0]}; end
      S_WR_DATA:  begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = 8'h30; bus_wdata_d = data_d; end
      S_INIT_SET: begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = 8'h08; bus_wdata_d = {511'b0, 1'b1}; end
      S_INIT_CLR, S_TO_CLR: begin bus_cs_d = 1'b1; bus_we_d = 1'b1; bus_addr_d = 8'h08; end
      S_POLL_REQ:    begin bus_cs_d = 1'b1; bus_addr_d = 8'h09; end
      S_RD_DATA_REQ: begin bus_cs_d = 1'b1; bus_addr_d = 8'h30; end
      S_RD_TAG_REQ:  begin bus_cs_d = 1'b1; bus_addr_d = 8'h40; end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      skip_q      <= '0;
      cyc_q       <= '0;
      encdec_q    <= 1'b0;
      key_reuse_q <= 1'b0;
      key_q       <= '0;
      nonce_q     <= '0;
      data_q      <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tag_ok_q    <= 1'b0;
      data_out_q  <= '0;
      tag_out_q   <= '0;
      bus_cs_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      skip_q      <= skip_d;
      cyc_q       <= cyc_d;
      encdec_q    <= encdec_d;
      key_reuse_q <= key_reuse_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tag_ok_q    <= tag_ok_d;
      data_out_q  <= data_out_d;
      tag_out_q   <= tag_out_d;
      bus_cs_q    <= bus_cs_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_chacha_aead_sequencer.sv
// Directed bench for chacha_aead_sequencer with a behavioural AEAD slave model.
module tb_chacha_aead_sequencer;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         ready;
  logic         encdec = 1'b0;
  logic         key_reuse = 1'b0;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [511:0] data_in = '0;
  logic         done, err, tag_ok;
  logic [511:0] data_out;
  logic [127:0] tag_out;
  logic         bus_cs, bus_we;
  logic [7:0]   bus_addr;
  logic [511:0] bus_wdata;
  logic [511:0] bus_rdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Slave model state
  logic [31:0]  s_mode = '0;
  logic [31:0]  s_key [8];
  logic [31:0]  s_nonce [3];
  logic [511:0] s_data = '0;
  int           s_init_cnt = 0;
  int           s_poll_idx = 0;
  int           stat_mode = 0;   // 0: valid 5 cycles after init, 1: stale pattern, 2: never
  logic         tag_bit = 1'b0;

  // Observed bus trace: {we, addr} and low data word
  logic [8:0]   tr_q[$];
  logic [31:0]  tr_dat_q[$];

  // Clock / reset block
  always #5 clk = ~clk;

  chacha_aead_sequencer #(.TIMEOUT_CYCLES(TO), .POLL_SKIP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .encdec(encdec),
    .key_reuse(key_reuse), .key(key), .nonce(nonce), .data_in(data_in),
    .done(done), .err(err), .tag_ok(tag_ok), .data_out(data_out), .tag_out(tag_out),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // AEAD slave model: registered reads, result = data ^ {key,key} ^ mode pattern.
  always @(posedge clk) begin
    logic v;
    if (s_init_cnt < 1000) s_init_cnt <= s_init_cnt + 1;
    if (bus_cs && bus_we) begin
      if (bus_addr == 8'h0a) s_mode <= bus_wdata[31:0];
      if (bus_addr >= 8'h10 && bus_addr <= 8'h17) s_key[bus_addr[2:0]] <= bus_wdata[31:0];
      if (bus_addr >= 8'h20 && bus_addr <= 8'h22) s_nonce[bus_addr[1:0]] <= bus_wdata[31:0];
      if (bus_addr == 8'h30) s_data <= bus_wdata;
      if (bus_addr == 8'h08 && bus_wdata[0]) begin
        s_init_cnt <= 0;
        s_poll_idx <= 0;
      end
    end
    if (bus_cs && !bus_we) begin
      if (bus_addr == 8'h09) begin
        case (stat_mode)
          0: v = (s_init_cnt >= 5);
          1: v = (s_poll_idx < 2) || (s_poll_idx >= 5);
          default: v = 1'b0;
        endcase
        bus_rdata  <= {509'b0, tag_bit, v, 1'b1};
        s_poll_idx <= s_poll_idx + 1;
      end
      if (bus_addr == 8'h30)
        bus_rdata <= s_data ^ {s_key[0], s_key[1], s_key[2], s_key[3], s_key[4], s_key[5], s_key[6], s_key[7],
                               s_key[0], s_key[1], s_key[2], s_key[3], s_key[4], s_key[5], s_key[6], s_key[7]}
                     ^ (s_mode[0] ? {16{32'h5a5a5a5a}} : 512'b0);
      if (bus_addr == 8'h40) bus_rdata <= {384'b0, s_nonce[2], s_nonce[1], s_nonce[0], s_mode};
    end
  end

  // Bus trace monitor
  always @(negedge clk) begin
    if (bus_cs) begin
      tr_q.push_back({bus_we, bus_addr});
      tr_dat_q.push_back(bus_wdata[31:0]);
    end
  end

  function automatic logic [511:0] exp_res(input logic ed, input logic [255:0] k, input logic [511:0] d);
    return d ^ {k, k} ^ (ed ? {16{32'h5a5a5a5a}} : 512'b0);
  endfunction

  function automatic logic [127:0] exp_tag(input logic ed, input logic [95:0] n);
    return {n, 31'b0, ed};
  endfunction

  // Driver: one request; lat counts cycles from the accepting edge to done.
  task automatic run_op(input logic ed, input logic kr, input logic [255:0] k, input logic [95:0] n,
                        input logic [511:0] d, input bit disturb, output int lat, output int done_at);
    int guard;
    guard = 0;
    while (!ready && guard < 100) begin @(negedge clk); guard++; end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_wait got %b want 1", ready); end
    tr_q.delete();
    tr_dat_q.delete();
    encdec = ed; key_reuse = kr; key = k; nonce = n; data_in = d; start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (disturb && !done) begin
        start = 1'($urandom_range(0, 1));
        encdec = ~encdec; key_reuse = ~key_reuse; key = ~key; nonce = ~nonce; data_in = ~data_in;
      end else begin
        start = 1'b0;
      end
    end while (!done && lat < 200);
    done_at = cyc;
    start = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL op_done_timeout got %b want 1 after %0d cycles", done, lat); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 10;
    if (ready !== 1'b1)    begin errors++; $display("FAIL rst_ready got %b want 1", ready); end
    if (done !== 1'b0)     begin errors++; $display("FAIL rst_done got %b want 0", done); end
    if (err !== 1'b0)      begin errors++; $display("FAIL rst_err got %b want 0", err); end
    if (tag_ok !== 1'b0)   begin errors++; $display("FAIL rst_tag_ok got %b want 0", tag_ok); end
    if (bus_cs !== 1'b0)   begin errors++; $display("FAIL rst_bus_cs got %b want 0", bus_cs); end
    if (bus_we !== 1'b0)   begin errors++; $display("FAIL rst_bus_we got %b want 0", bus_we); end
    if (bus_addr !== 8'h0) begin errors++; $display("FAIL rst_bus_addr got %h want 00", bus_addr); end
    if (bus_wdata !== '0)  begin errors++; $display("FAIL rst_bus_wdata got nonzero want 0"); end
    if (data_out !== '0)   begin errors++; $display("FAIL rst_data_out got nonzero want 0"); end
    if (tag_out !== '0)    begin errors++; $display("FAIL rst_tag_out got %h want 0", tag_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_encrypt();
    logic [8:0]   exp_q[$];
    logic [255:0] k;
    logic [95:0]  n;
    logic [511:0] d;
    int lat, dat;
    k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    n = 96'h000000090000004a00000000;
    d = {8{64'h0123456789abcdef}};
    stat_mode = 0; tag_bit = 1'b1;
    run_op(1'b1, 1'b0, k, n, d, 1'b0, lat, dat);
    exp_q.push_back(9'h10a);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, 8'h10 + 8'(i)});
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 8'h20 + 8'(i)});
    exp_q.push_back(9'h130); exp_q.push_back(9'h108); exp_q.push_back(9'h108);
    for (int i = 0; i < 3; i++) exp_q.push_back(9'h009);
    exp_q.push_back(9'h030); exp_q.push_back(9'h040);
    checks++;
    if (tr_q.size() != exp_q.size()) begin errors++; $display("FAIL enc_trace_len got %0d want %0d", tr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < tr_q.size(); i++) begin
      checks++;
      if (tr_q[i] !== exp_q[i]) begin errors++; $display("FAIL enc_trace[%0d] got %h want %h", i, tr_q[i], exp_q[i]); end
    end
    if (tr_dat_q.size() >= 15) begin
      checks += 6;
      if (tr_dat_q[0] !== 32'h1)         begin errors++; $display("FAIL enc_mode_word got %h want 1", tr_dat_q[0]); end
      if (tr_dat_q[1] !== 32'h00010203)  begin errors++; $display("FAIL enc_key_0x10 got %h want 00010203", tr_dat_q[1]); end
      if (tr_dat_q[8] !== 32'h1c1d1e1f)  begin errors++; $display("FAIL enc_key_0x17 got %h want 1c1d1e1f", tr_dat_q[8]); end
      if (tr_dat_q[9] !== 32'h00000000)  begin errors++; $display("FAIL enc_nonce_0x20 got %h want 0", tr_dat_q[9]); end
      if (tr_dat_q[11] !== 32'h00000009) begin errors++; $display("FAIL enc_nonce_0x22 got %h want 9", tr_dat_q[11]); end
      if (tr_dat_q[13] !== 32'h1 || tr_dat_q[14] !== 32'h0) begin
        errors++; $display("FAIL enc_init_words got %h/%h want 1/0", tr_dat_q[13], tr_dat_q[14]);
      end
    end
    checks += 5;
    if (lat != 26) begin errors++; $display("FAIL enc_latency got %0d want 26", lat); end
    if (data_out !== exp_res(1'b1, k, d)) begin errors++; $display("FAIL enc_data_out got %h want %h", data_out[63:0], exp_res(1'b1, k, d)); end
    if (tag_out !== exp_tag(1'b1, n)) begin errors++; $display("FAIL enc_tag_out got %h want %h", tag_out, exp_tag(1'b1, n)); end
    if (tag_ok !== 1'b1) begin errors++; $display("FAIL enc_tag_ok got %b want 1", tag_ok); end
    if (err !== 1'b0) begin errors++; $display("FAIL enc_err got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] k2;
    logic [95:0]  n3;
    logic [511:0] d2, d3;
    int lat_a, lat_b, dat_a, dat_b, key_wr;
    k2 = {8{32'hc3a51e77}};
    d2 = {16{32'h13572468}};
    n3 = 96'habcdef0123456789fedcba98;
    d3 = {16{32'h0f1e2d3c}};
    stat_mode = 0; tag_bit = 1'b0;
    run_op(1'b0, 1'b0, k2, 96'h1, d2, 1'b0, lat_a, dat_a);
    run_op(1'b0, 1'b1, ~k2, n3, d3, 1'b0, lat_b, dat_b);
    key_wr = 0;
    foreach (tr_q[i]) if (tr_q[i][8] && tr_q[i][7:0] >= 8'h10 && tr_q[i][7:0] <= 8'h17) key_wr++;
    checks += 7;
    if (key_wr != 0) begin errors++; $display("FAIL b2b_key_writes got %0d want 0", key_wr); end
    if (tr_q.size() != 12) begin errors++; $display("FAIL b2b_trace_len got %0d want 12", tr_q.size()); end
    if (lat_b != 18) begin errors++; $display("FAIL b2b_latency got %0d want 18", lat_b); end
    if (lat_a - lat_b != 8) begin errors++; $display("FAIL b2b_latency_delta got %0d want 8", lat_a - lat_b); end
    if (dat_b - dat_a != 19) begin errors++; $display("FAIL b2b_done_distance got %0d want 19", dat_b - dat_a); end
    if (data_out !== exp_res(1'b0, k2, d3)) begin errors++; $display("FAIL b2b_data_out got %h want %h", data_out[63:0], exp_res(1'b0, k2, d3)); end
    if (tag_out !== exp_tag(1'b0, n3) || tag_ok !== 1'b0) begin
      errors++; $display("FAIL b2b_tag got %h/%b want %h/0", tag_out, tag_ok, exp_tag(1'b0, n3));
    end
  endtask

  task automatic test_stale_status();
    logic [255:0] k;
    logic [511:0] d;
    int lat, dat, polls;
    k = {4{64'h8899aabbccddeeff}};
    d = {16{32'h600dcafe}};
    stat_mode = 1; tag_bit = 1'b1;
    run_op(1'b1, 1'b0, k, 96'h777, d, 1'b0, lat, dat);
    polls = 0;
    foreach (tr_q[i]) if (tr_q[i] == 9'h009) polls++;
    checks += 4;
    if (polls != 6) begin errors++; $display("FAIL stale_polls got %0d want 6", polls); end
    if (lat != 32) begin errors++; $display("FAIL stale_latency got %0d want 32", lat); end
    if (data_out !== exp_res(1'b1, k, d)) begin errors++; $display("FAIL stale_data_out got %h want %h", data_out[63:0], exp_res(1'b1, k, d)); end
    if (tag_ok !== 1'b1) begin errors++; $display("FAIL stale_tag_ok got %b want 1", tag_ok); end
  endtask

  task automatic test_timeout();
    logic [255:0] k;
    logic [511:0] d;
    int lat, dat, polls, last;
    k = {8{32'h0badf00d}};
    d = {16{32'h11112222}};
    stat_mode = 2; tag_bit = 1'b1;
    run_op(1'b1, 1'b0, k, 96'h5, d, 1'b0, lat, dat);
    polls = 0;
    foreach (tr_q[i]) if (tr_q[i] == 9'h009) polls++;
    last = tr_q.size() - 1;
    checks += 8;
    if (lat != 33) begin errors++; $display("FAIL to_latency got %0d want 33", lat); end
    if (polls != 8) begin errors++; $display("FAIL to_polls got %0d want 8", polls); end
    if (tr_q.size() != 24) begin errors++; $display("FAIL to_trace_len got %0d want 24", tr_q.size()); end
    if (last < 0 || tr_q[last] !== 9'h108 || tr_dat_q[last] !== 32'h0) begin
      errors++; $display("FAIL to_safety_clear got last access index %0d want write 08 data 0", last);
    end
    if (err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", err); end
    if (data_out !== '0) begin errors++; $display("FAIL to_data_out got %h want 0", data_out[63:0]); end
    if (tag_out !== '0) begin errors++; $display("FAIL to_tag_out got %h want 0", tag_out); end
    if (tag_ok !== 1'b0) begin errors++; $display("FAIL to_tag_ok got %b want 0", tag_ok); end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL to_err_hold got %b want 1", err); end
    stat_mode = 0;
    encdec = 1'b0; key_reuse = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL to_err_clear got %b want 0", err); end
    lat = 0;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL to_recover got done %b err %b want 1/0", done, err); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [255:0] k;
    logic [511:0] d;
    int guard, lat, dat;
    k = {8{32'h2468ace0}};
    d = {16{32'hfeedface}};
    stat_mode = 0; tag_bit = 1'b0;
    encdec = 1'b1; key_reuse = 1'b0; key = k; nonce = 96'h3; data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(bus_cs && bus_addr == 8'h12) && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (bus_addr !== 8'h12) begin errors++; $display("FAIL rmid_reach_wr_key got %h want 12", bus_addr); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 6;
    if (bus_cs !== 1'b0)   begin errors++; $display("FAIL rmid_bus_cs got %b want 0", bus_cs); end
    if (ready !== 1'b1)    begin errors++; $display("FAIL rmid_ready got %b want 1", ready); end
    if (done !== 1'b0)     begin errors++; $display("FAIL rmid_done got %b want 0", done); end
    if (bus_addr !== 8'h0) begin errors++; $display("FAIL rmid_bus_addr got %h want 00", bus_addr); end
    if (data_out !== '0 || tag_out !== '0) begin errors++; $display("FAIL rmid_results got nonzero want 0"); end
    if (err !== 1'b0 || tag_ok !== 1'b0) begin errors++; $display("FAIL rmid_flags got %b/%b want 0/0", err, tag_ok); end
    run_op(1'b0, 1'b0, k, 96'h3, d, 1'b0, lat, dat);
    checks += 3;
    if (tr_q.size() < 1 || tr_q[0] !== 9'h10a) begin errors++; $display("FAIL rmid_first_access want write 0a"); end
    if (tr_q.size() != 20) begin errors++; $display("FAIL rmid_trace_len got %0d want 20", tr_q.size()); end
    if (data_out !== exp_res(1'b0, k, d)) begin errors++; $display("FAIL rmid_data_out got %h want %h", data_out[63:0], exp_res(1'b0, k, d)); end
  endtask

  task automatic test_busy_start();
    logic [255:0] k;
    logic [95:0]  n;
    logic [511:0] d;
    int lat, dat, extra;
    k = {8{32'h31415926}};
    n = 96'h0102030405060708090a0b0c;
    d = {16{32'h27182818}};
    stat_mode = 0; tag_bit = 1'b1;
    run_op(1'b1, 1'b0, k, n, d, 1'b1, lat, dat);
    checks += 4;
    if (lat != 26) begin errors++; $display("FAIL busy_latency got %0d want 26", lat); end
    if (tr_q.size() != 20) begin errors++; $display("FAIL busy_trace_len got %0d want 20", tr_q.size()); end
    if (data_out !== exp_res(1'b1, k, d)) begin errors++; $display("FAIL busy_data_out got %h want %h", data_out[63:0], exp_res(1'b1, k, d)); end
    if (tag_out !== exp_tag(1'b1, n)) begin errors++; $display("FAIL busy_tag_out got %h want %h", tag_out, exp_tag(1'b1, n)); end
    extra = 0;
    repeat (5) begin @(negedge clk); if (done || !ready) extra++; end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL busy_no_extra_op got %0d busy cycles want 0", extra); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encrypt();
    test_back_to_back();
    test_stale_status();
    test_timeout();
    test_reset_mid_op();
    test_busy_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chacha_aead_sequencer.md
Name: chacha_aead_sequencer

Overview:
- Bus-master controller that runs one complete ChaCha20-Poly1305 block operation on the memory-mapped AEAD register bus on behalf of a single requester.
- Takes key, nonce, 512-bit block and direction in one start handshake.
- Programs the engine, pulses init, polls status, reads back data and tag, then returns a done pulse with results.
- Sits between the requester (DMA/host logic) and the AEAD bus slave.

Parameters:
- TIMEOUT_CYCLES, 4096, max cycles in the poll phase before aborting with err.
- POLL_SKIP, 2, number of initial status reads ignored after init clear (stale-valid guard).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  request strobe, accepted when ready=1
- ready  out  1  high only in IDLE
- encdec  in  1  direction bit, written to the mode register (0x0a)
- key_reuse  in  1  1 = skip the key writes and keep the engine's current key
- key  in  256  key; key[255:224] goes to 0x10 … key[31:0] goes to 0x17
- nonce  in  96  nonce; nonce[31:0] goes to 0x20, [63:32] to 0x21, [95:64] to 0x22
- data_in  in  512  block written whole to 0x30
- done  out  1  one-cycle completion pulse
- err  out  1  timeout flag, valid with done
- tag_ok  out  1  status bit2 captured at completion
- data_out  out  512  result block
- tag_out  out  128  read_data[127:0] of the 0x40 read
- bus_cs  out  1  slave chip select
- bus_we  out  1  slave write enable
- bus_addr  out  8  slave address
- bus_wdata  out  512  slave write data; 32-bit words in [31:0], upper bits 0
- bus_rdata  in  512  slave read data, registered by the slave: valid 1 cycle after a read cycle

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-operation):
  - state=IDLE; ready=1.
  - done, err, tag_ok=0; data_out, tag_out=0.
  - bus_cs, bus_we=0; bus_addr=0; bus_wdata=0.
- All outputs are registered. The bus is driven one access per cycle; bus_cs=0 in IDLE and DONE.
- Start acceptance: start&&ready latches encdec, key_reuse, key, nonce and data_in into internal registers. Later changes on the inputs are ignored. start while busy is ignored.
- FSM states and transitions:
  - IDLE -> WR_MODE: write 0x0a with bit0=encdec.
  - WR_MODE -> WR_KEY, or directly to WR_NONCE if key_reuse.
  - WR_KEY: 8 cycles, addresses 0x10..0x17, 3-bit word counter.
  - WR_NONCE: 3 cycles, addresses 0x20..0x22.
  - WR_DATA: write 0x30 with the full block.
  - INIT_SET: write 0x08 with data 1.
  - INIT_CLR: write 0x08 with data 0.
  - POLL_REQ: read 0x09.
  - POLL_CHK: bus_cs=0; sample bus_rdata[2:0].
    - If skip counter < POLL_SKIP: increment it, go to POLL_REQ.
    - Else if bit0 (ready) and bit1 (valid) are both 1: capture tag_ok=bit2, go to RD_DATA_REQ.
    - Else go to POLL_REQ.
  - RD_DATA_REQ: read 0x30. RD_DATA_CAP: data_out<=bus_rdata.
  - RD_TAG_REQ: read 0x40. RD_TAG_CAP: tag_out<=bus_rdata[127:0].
  - RD_TAG_CAP -> DONE.
  - DONE: done=1 for exactly one cycle, then IDLE with ready=1. Next start is accepted the cycle after DONE.
- Latency with no polling stall and key written:
  - 15 write cycles (1 mode + 8 key + 3 nonce + 1 data + 2 init).
  - Poll phase: 2*(POLL_SKIP+1) cycles.
  - Readback: 4 cycles.
  - DONE: 1 cycle.
  - Total = 26 cycles from start to done at defaults. key_reuse subtracts 8.
- Timeout:
  - The cycle counter clears on entering INIT_CLR and counts every cycle in POLL_REQ/POLL_CHK.
  - When it reaches TIMEOUT_CYCLES: go to TO_CLR, which writes 0x08 with data 0 as a safety clear.
  - Then DONE with err=1, data_out=0, tag_out=0, tag_ok=0.
  - err holds until the next start is accepted. data_out, tag_out and tag_ok also hold until the next accepted start.
- Status bits above [2] are ignored.

Test Plan:
- Encrypt, key=256'h00010203…1e1f, nonce=96'h000000090000004a00000000, key_reuse=0, slave model asserts valid 5 cycles after init:
  - Bus trace is exactly 0x0a,0x10..0x17,0x20..0x22,0x30,0x08(1),0x08(0), then polls.
  - Key word at 0x10=32'h00010203; nonce word at 0x20=32'h00000000.
  - done pulses once; data_out and tag_out match the model output.
- Back-to-back requests with key_reuse=1 on the second:
  - Second trace contains no 0x10-0x17 writes.
  - done-to-done distance = previous minus 8 cycles.
- Stale status: model returns valid=1 on the first 2 polls, then 0 for 3 polls, then 1:
  - The first two reads are ignored and completion waits for the later valid.
- Timeout: model never sets valid, TIMEOUT_CYCLES=16:
  - 0x08(0) write issued; done with err=1 and data_out=0.
  - The next start clears err.
- Reset asserted during WR_KEY:
  - Next cycle: bus_cs=0, ready=1, done=0, outputs zero.
  - A fresh start runs the full sequence from 0x0a.
- start pulsed while busy and inputs changed mid-operation:
  - Ignored; the results reflect the originally latched values.
